// File: rtl/recorder_pkg.sv
// Shared types and default sizing for the audio recorder/looper.
package recorder_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 16384;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  // Mode of the recorder; mirrors the previous-cycle record_in.
  typedef enum logic {
    PLAY   = 1'b0,
    RECORD = 1'b1
  } rec_state_t;

  typedef logic [DEF_WIDTH-1:0] sample_t;

  // What the output register does once the buffer read has completed.
  typedef enum logic [1:0] {
    OUT_HOLD = 2'd0,
    OUT_ZERO = 2'd1,
    OUT_READ = 2'd2
  } out_op_t;

endpackage

// File: rtl/recorder_bram.sv
// Simple dual-port inferred block RAM: one write port, one registered read port.
module recorder_bram #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16384,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port.
  // NOTE: the array has no reset so it maps onto block RAM; a reset would force it into flops.
  always_ff @(posedge clk_in) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: one-cycle registered read.
  always_ff @(posedge clk_in) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/audio_recorder.sv
// Single-channel recorder/looper: records valid samples while record_in is high,
// then loops the clip one sample per strobe while record_in is low.
module audio_recorder
  import recorder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             record_in,
  input  logic             audio_valid_in,
  input  logic [WIDTH-1:0] audio_in,
  output logic [WIDTH-1:0] single_out
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;
  localparam logic [LEN_W-1:0]  FULL_LEN  = LEN_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rec_state_t        r_state;     // doubles as the registered record_in for edge detection
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [LEN_W-1:0]  r_length;
  out_op_t           r_op;

  logic              w_rise;
  logic              w_fall;
  logic              w_empty;
  logic              w_full;
  logic              w_we;
  logic              w_re;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;
  logic              w_last;
  logic [WIDTH-1:0]  w_rdata;
  out_op_t           w_op;

  assign w_rise  = record_in  && (r_state == PLAY);
  assign w_fall  = !record_in && (r_state == RECORD);
  assign w_empty = (r_length == '0);
  assign w_full  = (r_length == FULL_LEN);

  // A new take restarts at address 0 in the very cycle record_in rises.
  assign w_waddr = w_rise ? '0 : r_wr_addr;
  assign w_we    = record_in && audio_valid_in && (w_rise || !w_full);

  // Playback restarts at the first sample in the very cycle record_in falls.
  assign w_raddr = w_fall ? '0 : r_rd_addr;
  assign w_re    = !record_in && audio_valid_in && !w_empty;
  assign w_last  = ({1'b0, w_raddr} == (r_length - LEN_W'(1)));

  assign w_op = (record_in || w_empty) ? OUT_ZERO :
                audio_valid_in         ? OUT_READ : OUT_HOLD;

  recorder_bram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_bram (
    .clk_in  (clk_in),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (audio_in),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Mode tracking, write/read pointers and clip length.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= PLAY;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_length  <= '0;
    end else begin
      r_state <= record_in ? RECORD : PLAY;
      if (record_in) begin
        // Length and write pointer saturate once the buffer is full.
        r_length  <= (w_rise ? '0 : r_length) + LEN_W'(w_we);
        r_wr_addr <= (w_we && (w_waddr != LAST_ADDR)) ? w_waddr + ADDR_W'(1) : w_waddr;
      end else if (w_re) begin
        r_rd_addr <= w_last ? '0 : w_raddr + ADDR_W'(1);
      end else if (w_empty) begin
        r_rd_addr <= '0;
      end else begin
        r_rd_addr <= w_raddr;
      end
    end
  end

  // Output stage: the op travels alongside the buffer read, then updates single_out.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_op       <= OUT_ZERO;
      single_out <= '0;
    end else begin
      r_op <= w_op;
      case (r_op)
        OUT_READ: single_out <= w_rdata;
        OUT_ZERO: single_out <= '0;
        default:  single_out <= single_out;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_recorder.sv
// Scoreboard bench for audio_recorder: a default-depth instance and a 16-deep
// instance share the stimulus; expected outputs are queued per driven cycle.
module tb_audio_recorder;

  localparam int SMALL_DEPTH = 16;
  localparam int BIG_DEPTH   = 16384;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       record_in = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] audio_in = 8'h00;
  logic [7:0] out_big;
  logic [7:0] out_small;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int         due;
    logic [7:0] v_big;
    logic [7:0] v_small;
  } exp_t;

  exp_t q[$];

  // Behavioural model: the recorded clip per instance and the playback index.
  logic [7:0] clip [2][BIG_DEPTH];
  int         len  [2];
  int         idx  [2];
  int         dep  [2];
  logic [7:0] last [2];
  bit         prev_rec;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_recorder u_big (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .record_in      (record_in),
    .audio_valid_in (valid),
    .audio_in       (audio_in),
    .single_out     (out_big)
  );

  audio_recorder #(
    .WIDTH (8),
    .DEPTH (SMALL_DEPTH)
  ) u_small (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .record_in      (record_in),
    .audio_valid_in (valid),
    .audio_in       (audio_in),
    .single_out     (out_small)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < 2; j++) begin
      len[j]  = 0;
      idx[j]  = 0;
      last[j] = 8'h00;
    end
    prev_rec = 1'b0;
  endtask

  // Drive one cycle of inputs and queue the output expected two cycles later.
  task automatic drive(input bit rec, input bit vld, input logic [7:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    record_in = rec;
    valid     = vld;
    audio_in  = d;
    for (int j = 0; j < 2; j++) begin
      if (rec) begin
        if (!prev_rec) len[j] = 0;
        if (vld && len[j] < dep[j]) begin
          clip[j][len[j]] = d;
          len[j]++;
        end
        last[j] = 8'h00;
      end else begin
        if (prev_rec) idx[j] = 0;
        if (len[j] == 0) begin
          last[j] = 8'h00;
        end else if (vld) begin
          last[j] = clip[j][idx[j]];
          idx[j]  = (idx[j] + 1) % len[j];
        end
      end
    end
    prev_rec  = rec;
    e.due     = cyc + 2;
    e.v_big   = last[0];
    e.v_small = last[1];
    q.push_back(e);
  endtask

  task automatic play_strobes(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b1, 8'hEE);
      for (int g = 1; g < gap; g++) drive(1'b0, 1'b0, 8'hEE);
    end
  endtask

  // Monitor: compares both outputs whenever a queued expectation falls due.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check("due_cycle", 32'(e.due), 32'(cyc));
      check("out_big", 32'(out_big), 32'(e.v_big));
      check("out_small", 32'(out_small), 32'(e.v_small));
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dep[0] = BIG_DEPTH;
    dep[1] = SMALL_DEPTH;
    model_clear();

    // Reset held for a cycle: outputs must read zero.
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_big", 32'(out_big), 32'h0);
    check("reset_small", 32'(out_small), 32'h0);
    #1 rst_n = 1'b1;

    // Playback with nothing recorded yields zero.
    play_strobes(4, 3);

    // Record a 10000-sample ramp (small instance keeps only 16).
    for (int i = 0; i < 10000; i++) drive(1'b1, 1'b1, 8'(i));

    // Slow strobes, then a back-to-back stretch that wraps the clip, then slow again.
    play_strobes(20, 7);
    play_strobes(10000, 1);
    play_strobes(10, 7);

    // Overflow take of 20 samples: small instance drops 16..19.
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 8'(i));
    play_strobes(20, 7);

    // Short re-record with idle cycles in between; the long clip is forgotten.
    drive(1'b1, 1'b1, 8'hA1);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b1, 8'hA2);
    drive(1'b1, 1'b1, 8'hA3);
    drive(1'b1, 1'b0, 8'h66);
    play_strobes(8, 3);

    // Asynchronous reset between clock edges during playback.
    play_strobes(2, 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_big", 32'(out_big), 32'h0);
    check("async_reset_small", 32'(out_small), 32'h0);
    q.delete();
    model_clear();
    record_in = 1'b0;
    valid     = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // After reset the clip length is zero, so playback yields zero.
    play_strobes(5, 3);
    drive(1'b0, 1'b0, 8'h00);

    // Let the scoreboard drain.
    repeat (4) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
